// File: rtl/bootrom_line_fetch.sv
// Boot ROM line-fill engine: fetches one I-cache line as BEATS single classic
// Wishbone reads, then presents it to the cache with a valid/ack handshake.
module bootrom_line_fetch #(
  parameter int WID     = 64,
  parameter int BEATS   = 4,
  parameter int AW      = 18,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [AW-1:0]        req_adr_i,
  output logic                 req_rdy_o,
  output logic                 line_vld_o,
  input  logic                 line_ack_i,
  output logic [WID*BEATS-1:0] line_o,
  output logic [AW-1:0]        line_adr_o,
  output logic                 line_err_o,
  output logic                 m_cs_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic [2:0]           m_cti_o,
  output logic [AW-1:0]        m_adr_o,
  input  logic                 m_ack_i,
  input  logic [WID-1:0]       m_dat_i
);

  localparam int BB = WID / 8;
  localparam int LO = $clog2(BEATS * BB);
  localparam int BW = $clog2(BEATS);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] BEAT_STEP = AW'(BB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_GAP,
    S_DONE
  } state_t;

  state_t                     state;
  logic [BW-1:0]              beat;
  logic [TW-1:0]              tmo;
  logic                       bus_q;
  logic [BEATS-1:0][WID-1:0]  line_q;
  logic [AW-1:0]              base;
  logic                       unused_offset;

  // The line offset bits of the miss address never reach the ROM.
  assign base          = {req_adr_i[AW-1:LO], {LO{1'b0}}};
  assign unused_offset = ^req_adr_i[LO-1:0];

  assign m_cs_o  = bus_q;
  assign m_cyc_o = bus_q;
  assign m_stb_o = bus_q;
  assign m_cti_o = 3'b000;
  assign line_o  = line_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      req_rdy_o  <= 1'b1;
      line_vld_o <= 1'b0;
      line_err_o <= 1'b0;
      bus_q      <= 1'b0;
      m_adr_o    <= '0;
      line_q     <= '0;
      line_adr_o <= '0;
      beat       <= '0;
      tmo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            line_adr_o <= base;
            m_adr_o    <= base;
            beat       <= '0;
            tmo        <= '0;
            bus_q      <= 1'b1;
            req_rdy_o  <= 1'b0;
            state      <= S_BUS;
          end
        end
        S_BUS: begin
          // An ack arriving in the last allowed cycle still counts as success.
          if (m_ack_i) begin
            line_q[beat] <= m_dat_i;
            bus_q        <= 1'b0;
            state        <= S_GAP;
          end else if (tmo == TMO_LAST) begin
            bus_q      <= 1'b0;
            line_err_o <= 1'b1;
            line_vld_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_GAP: begin
          if (beat == LAST_BEAT) begin
            line_vld_o <= 1'b1;
            state      <= S_DONE;
          end else begin
            beat    <= beat + 1'b1;
            tmo     <= '0;
            m_adr_o <= m_adr_o + BEAT_STEP;
            bus_q   <= 1'b1;
            state   <= S_BUS;
          end
        end
        S_DONE: begin
          if (line_ack_i) begin
            line_vld_o <= 1'b0;
            line_err_o <= 1'b0;
            req_rdy_o  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_err_has_vld: assert property (@(posedge clk_i) disable iff (!rst_i)
    line_err_o |-> line_vld_o);

  a_rdy_only_idle: assert property (@(posedge clk_i) disable iff (!rst_i)
    req_rdy_o |-> (!m_stb_o && !line_vld_o));

  a_adr_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (m_stb_o && !m_ack_i) |=> $stable(m_adr_o));

endmodule

// File: tb/tb_bootrom_line_fetch.sv
// Directed bench for bootrom_line_fetch: a behavioural ROM with configurable
// ack latency drives the Wishbone side while each task exercises one scenario.
module tb_bootrom_line_fetch;

  localparam int WID     = 64;
  localparam int BEATS   = 4;
  localparam int AW      = 18;
  localparam int TIMEOUT = 63;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 req_i;
  logic [AW-1:0]        req_adr_i;
  logic                 req_rdy_o;
  logic                 line_vld_o;
  logic                 line_ack_i;
  logic [WID*BEATS-1:0] line_o;
  logic [AW-1:0]        line_adr_o;
  logic                 line_err_o;
  logic                 m_cs_o;
  logic                 m_cyc_o;
  logic                 m_stb_o;
  logic [2:0]           m_cti_o;
  logic [AW-1:0]        m_adr_o;
  logic                 m_ack_i;
  logic [WID-1:0]       m_dat_i;

  logic                 stray_ack = 1'b0;
  logic                 rom_ack   = 1'b0;
  logic [WID-1:0]       rom_dat   = '0;
  logic                 second    = 1'b0;
  int                   cnt       = 0;
  int                   rom_lat   = 5;
  bit                   dbl       = 1'b0;
  bit                   blk_en    = 1'b0;
  logic [AW-1:0]        blk_adr   = '0;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] iss_adr[$];
  int            iss_cyc[$];
  int            stb_cycles;
  int            rdy_busy;
  int            adr_moves;
  int            bus_bad;

  always #5 clk_i = ~clk_i;

  bootrom_line_fetch #(
    .WID    (WID),
    .BEATS  (BEATS),
    .AW     (AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .req_adr_i (req_adr_i),
    .req_rdy_o (req_rdy_o),
    .line_vld_o(line_vld_o),
    .line_ack_i(line_ack_i),
    .line_o    (line_o),
    .line_adr_o(line_adr_o),
    .line_err_o(line_err_o),
    .m_cs_o    (m_cs_o),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_cti_o   (m_cti_o),
    .m_adr_o   (m_adr_o),
    .m_ack_i   (m_ack_i),
    .m_dat_i   (m_dat_i)
  );

  assign m_ack_i = rom_ack | stray_ack;
  assign m_dat_i = stray_ack ? 64'hBAD0_BAD0_BAD0_BAD0 : rom_dat;

  function automatic logic [WID-1:0] rom_word(input logic [AW-4:0] idx);
    return {32'hB007_0000 | {17'b0, idx}, 32'hFFFF_FFFF ^ {17'b0, idx}};
  endfunction

  // ROM: ack arrives rom_lat cycles into the strobe; dbl stretches it into the gap with junk data.
  always @(posedge clk_i) begin
    if (rom_ack && dbl && !second) begin
      second  <= 1'b1;
      rom_dat <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (m_stb_o && !rom_ack) begin
      if (cnt == rom_lat - 2 && !(blk_en && m_adr_o == blk_adr)) begin
        rom_ack <= 1'b1;
        rom_dat <= rom_word(m_adr_o[AW-1:3]);
        cnt     <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      rom_ack <= 1'b0;
      second  <= 1'b0;
      cnt     <= 0;
    end
  end

  function automatic logic [4*AW-1:0] pack_adr();
    logic [4*AW-1:0] r;
    r = '1;
    for (int i = 0; i < 4; i++)
      if (i < iss_adr.size()) r[(3-i)*AW +: AW] = iss_adr[i];
    return r;
  endfunction

  function automatic logic [31:0] pack_cyc();
    logic [31:0] r;
    r = '1;
    for (int i = 0; i < 4; i++)
      if (i < iss_cyc.size()) r[(3-i)*8 +: 8] = 8'(iss_cyc[i]);
    return r;
  endfunction

  task automatic run_fill(input logic [AW-1:0] adr, input bit busy_pulse, output int vld_cycle);
    logic          prev_stb;
    logic [AW-1:0] prev_adr;
    iss_adr.delete();
    iss_cyc.delete();
    stb_cycles = 0;
    rdy_busy   = 0;
    adr_moves  = 0;
    bus_bad    = 0;
    vld_cycle  = -1;
    prev_stb   = 1'b0;
    prev_adr   = '0;
    req_adr_i  = adr;
    req_i      = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk_i);
      req_i = busy_pulse && (cyc >= 3) && (cyc <= 5);
      if (busy_pulse && cyc == 3) req_adr_i = 18'h00200;
      if (m_stb_o) stb_cycles++;
      if (m_stb_o && !prev_stb) begin
        iss_adr.push_back(m_adr_o);
        iss_cyc.push_back(cyc);
      end
      if (m_stb_o && prev_stb && m_adr_o != prev_adr) adr_moves++;
      if (m_cs_o !== m_stb_o || m_cyc_o !== m_stb_o || m_cti_o !== 3'b000) bus_bad++;
      if (req_rdy_o) rdy_busy++;
      prev_stb = m_stb_o;
      prev_adr = m_adr_o;
      if (line_vld_o) begin
        vld_cycle = cyc;
        break;
      end
    end
    req_i = 1'b0;
  endtask

  task automatic ack_line();
    line_ack_i = 1'b1;
    @(negedge clk_i);
    line_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b0; req_adr_i = '0; line_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (req_rdy_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_rdy: got %b expected 1", req_rdy_o); end
    checks++; if (line_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_vld: got %b expected 0", line_vld_o); end
    checks++; if (line_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", line_err_o); end
    checks++; if ({m_cs_o, m_cyc_o, m_stb_o} !== 3'b000) begin errors++; $display("[TB] FAIL rst_bus: got %b expected 000", {m_cs_o, m_cyc_o, m_stb_o}); end
    checks++; if (m_adr_o !== '0) begin errors++; $display("[TB] FAIL rst_madr: got %h expected 0", m_adr_o); end
    checks++; if (line_o !== '0) begin errors++; $display("[TB] FAIL rst_line: got %h expected 0", line_o); end
    checks++; if (line_adr_o !== '0) begin errors++; $display("[TB] FAIL rst_ladr: got %h expected 0", line_adr_o); end
    checks++; if (m_cti_o !== 3'b000) begin errors++; $display("[TB] FAIL rst_cti: got %b expected 000", m_cti_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic_fill();
    int vc;
    rom_lat = 5; dbl = 1'b0; blk_en = 1'b0;
    run_fill(18'h00040, 1'b0, vc);
    checks++; if (vc !== 25) begin errors++; $display("[TB] FAIL t1_latency: got %0d expected 25", vc); end
    checks++; if (pack_adr() !== {18'h00040, 18'h00048, 18'h00050, 18'h00058}) begin errors++; $display("[TB] FAIL t1_addrs: got %h expected %h", pack_adr(), {18'h00040, 18'h00048, 18'h00050, 18'h00058}); end
    checks++; if (pack_cyc() !== {8'd1, 8'd7, 8'd13, 8'd19}) begin errors++; $display("[TB] FAIL t1_issue_cycles: got %h expected 01070d13", pack_cyc()); end
    checks++; if (line_o !== {64'hB007000B_FFFFFFF4, 64'hB007000A_FFFFFFF5, 64'hB0070009_FFFFFFF6, 64'hB0070008_FFFFFFF7}) begin errors++; $display("[TB] FAIL t1_line: got %h", line_o); end
    checks++; if (line_adr_o !== 18'h00040) begin errors++; $display("[TB] FAIL t1_ladr: got %h expected 00040", line_adr_o); end
    checks++; if (line_err_o !== 1'b0) begin errors++; $display("[TB] FAIL t1_err: got %b expected 0", line_err_o); end
    checks++; if (rdy_busy !== 0) begin errors++; $display("[TB] FAIL t1_rdy_busy: got %0d cycles expected 0", rdy_busy); end
    checks++; if (adr_moves !== 0 || bus_bad !== 0) begin errors++; $display("[TB] FAIL t1_bus_stable: moves %0d bad %0d expected 0 0", adr_moves, bus_bad); end
    ack_line();
    checks++; if ({req_rdy_o, line_vld_o} !== 2'b10) begin errors++; $display("[TB] FAIL t1_release: got rdy/vld %b expected 10", {req_rdy_o, line_vld_o}); end
  endtask

  task automatic test_offset_ignored();
    int vc;
    rom_lat = 3; dbl = 1'b1; blk_en = 1'b0;
    run_fill(18'h0005D, 1'b0, vc);
    checks++; if (vc !== 17) begin errors++; $display("[TB] FAIL t2_latency: got %0d expected 17", vc); end
    checks++; if (pack_cyc() !== {8'd1, 8'd5, 8'd9, 8'd13}) begin errors++; $display("[TB] FAIL t2_issue_cycles: got %h expected 0105090d", pack_cyc()); end
    checks++; if (line_adr_o !== 18'h00040) begin errors++; $display("[TB] FAIL t2_ladr: got %h expected 00040", line_adr_o); end
    checks++; if (line_o !== {64'hB007000B_FFFFFFF4, 64'hB007000A_FFFFFFF5, 64'hB0070009_FFFFFFF6, 64'hB0070008_FFFFFFF7}) begin errors++; $display("[TB] FAIL t2_line: got %h", line_o); end
    ack_line();
    dbl = 1'b0;
  endtask

  task automatic test_top_wrap();
    int vc;
    rom_lat = 2; dbl = 1'b0; blk_en = 1'b0;
    run_fill(18'h3FFF8, 1'b0, vc);
    checks++; if (vc !== 13) begin errors++; $display("[TB] FAIL t3_latency: got %0d expected 13", vc); end
    checks++; if (pack_adr() !== {18'h3FFE0, 18'h3FFE8, 18'h3FFF0, 18'h3FFF8}) begin errors++; $display("[TB] FAIL t3_addrs: got %h expected %h", pack_adr(), {18'h3FFE0, 18'h3FFE8, 18'h3FFF0, 18'h3FFF8}); end
    checks++; if (line_adr_o !== 18'h3FFE0) begin errors++; $display("[TB] FAIL t3_ladr: got %h expected 3ffe0", line_adr_o); end
    checks++; if (line_err_o !== 1'b0) begin errors++; $display("[TB] FAIL t3_err: got %b expected 0", line_err_o); end
    checks++; if (line_o !== {64'hB0077FFF_FFFF8000, 64'hB0077FFE_FFFF8001, 64'hB0077FFD_FFFF8002, 64'hB0077FFC_FFFF8003}) begin errors++; $display("[TB] FAIL t3_line: got %h", line_o); end
    ack_line();
  endtask

  task automatic test_timeout();
    int vc;
    rom_lat = 5; dbl = 1'b0; blk_en = 1'b1; blk_adr = 18'h00110;
    run_fill(18'h00100, 1'b0, vc);
    checks++; if (vc !== 76) begin errors++; $display("[TB] FAIL t4_latency: got %0d expected 76", vc); end
    checks++; if (stb_cycles !== 73) begin errors++; $display("[TB] FAIL t4_stb_cycles: got %0d expected 73", stb_cycles); end
    checks++; if (iss_adr.size() !== 3) begin errors++; $display("[TB] FAIL t4_beats_issued: got %0d expected 3", iss_adr.size()); end
    checks++; if ({line_vld_o, line_err_o, m_stb_o} !== 3'b110) begin errors++; $display("[TB] FAIL t4_err_line: got vld/err/stb %b expected 110", {line_vld_o, line_err_o, m_stb_o}); end
    checks++; if (line_adr_o !== 18'h00100) begin errors++; $display("[TB] FAIL t4_ladr: got %h expected 00100", line_adr_o); end
    ack_line();
    checks++; if ({req_rdy_o, line_vld_o, line_err_o} !== 3'b100) begin errors++; $display("[TB] FAIL t4_release: got rdy/vld/err %b expected 100", {req_rdy_o, line_vld_o, line_err_o}); end
    blk_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int vc;
    int hold_bad;
    logic [WID*BEATS-1:0] exp_line;
    exp_line = {64'hB0070013_FFFFFFEC, 64'hB0070012_FFFFFFED, 64'hB0070011_FFFFFFEE, 64'hB0070010_FFFFFFEF};
    rom_lat = 2; dbl = 1'b0; blk_en = 1'b0;
    run_fill(18'h00080, 1'b1, vc);
    checks++; if (vc !== 13) begin errors++; $display("[TB] FAIL t5_latency: got %0d expected 13", vc); end
    checks++; if (pack_adr() !== {18'h00080, 18'h00088, 18'h00090, 18'h00098}) begin errors++; $display("[TB] FAIL t5_addrs: got %h expected %h", pack_adr(), {18'h00080, 18'h00088, 18'h00090, 18'h00098}); end
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      req_i     = (i >= 4) && (i < 9);
      req_adr_i = 18'h00200;
      @(negedge clk_i);
      if (line_o !== exp_line || line_adr_o !== 18'h00080 || line_vld_o !== 1'b1 ||
          line_err_o !== 1'b0 || m_stb_o !== 1'b0 || req_rdy_o !== 1'b0) hold_bad++;
    end
    checks++; if (hold_bad !== 0) begin errors++; $display("[TB] FAIL t5_hold: got %0d unstable cycles expected 0", hold_bad); end
    req_i = 1'b1; req_adr_i = 18'h00200; line_ack_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0; line_ack_i = 1'b0;
    checks++; if ({req_rdy_o, line_vld_o, m_stb_o} !== 3'b100) begin errors++; $display("[TB] FAIL t5_ack_release: got rdy/vld/stb %b expected 100", {req_rdy_o, line_vld_o, m_stb_o}); end
    @(negedge clk_i);
    checks++; if ({m_stb_o, req_rdy_o} !== 2'b01) begin errors++; $display("[TB] FAIL t5_req_lost: got stb/rdy %b expected 01", {m_stb_o, req_rdy_o}); end
  endtask

  task automatic test_reset_mid_beat();
    int   rises;
    int   after;
    logic prev;
    rom_lat = 10; dbl = 1'b0; blk_en = 1'b0;
    rises = 0; after = 0; prev = 1'b0;
    req_adr_i = 18'h00040; req_i = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      req_i = 1'b0;
      if (m_stb_o && !prev) rises++;
      prev = m_stb_o;
      if (rises == 2) after++;
      if (after == 3) break;
    end
    checks++; if (rises !== 2 || m_stb_o !== 1'b1 || m_adr_o !== 18'h00048) begin errors++; $display("[TB] FAIL t6_in_beat1: got rises %0d stb %b adr %h expected 2 1 00048", rises, m_stb_o, m_adr_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({m_cs_o, m_cyc_o, m_stb_o} !== 3'b000) begin errors++; $display("[TB] FAIL t6_bus_drop: got %b expected 000", {m_cs_o, m_cyc_o, m_stb_o}); end
    checks++; if ({req_rdy_o, line_vld_o, line_err_o} !== 3'b100) begin errors++; $display("[TB] FAIL t6_ctrl: got rdy/vld/err %b expected 100", {req_rdy_o, line_vld_o, line_err_o}); end
    checks++; if (m_adr_o !== '0 || line_adr_o !== '0) begin errors++; $display("[TB] FAIL t6_addr_clr: got %h %h expected 0 0", m_adr_o, line_adr_o); end
    rst_i = 1'b1; stray_ack = 1'b1;
    @(negedge clk_i);
    stray_ack = 1'b0;
    @(negedge clk_i);
    checks++; if ({m_stb_o, line_vld_o, req_rdy_o} !== 3'b001) begin errors++; $display("[TB] FAIL t6_late_ack: got stb/vld/rdy %b expected 001", {m_stb_o, line_vld_o, req_rdy_o}); end
    checks++; if (line_o !== '0) begin errors++; $display("[TB] FAIL t6_line_clean: got %h expected 0", line_o); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_offset_ignored();
    test_top_wrap();
    test_timeout();
    test_back_to_back();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1);
  end

endmodule
